// File: rtl/modq_pkg.sv
// modq_pkg: shared constants, types and state encoding for the Q=769 modular inverter
package modq_pkg;
  localparam int Q = 769;
  localparam int W = 10;
  localparam int MU = (1 << (2 * W)) / Q;
  typedef logic [W-1:0] residue_t;
  typedef logic [2*W-1:0] product_t;
  localparam residue_t EXP = residue_t'(Q - 2);
  typedef enum logic [2:0] {IDLE, SQR, MUL, CHK, DONE} modinv_state_t;
  function automatic int popcount(input residue_t v);
    int n;
    n = 0;
    for (int k = 0; k < W; k++) n += int'(v[k]);
    return n;
  endfunction
`ifdef MODINV_SELFCHECK_EN
  localparam int LATENCY = W + popcount(EXP) + 1;
`else
  localparam int LATENCY = W + popcount(EXP);
`endif
endpackage

// File: rtl/modq_mulred.sv
// modq_mulred: combinational residue multiply followed by Barrett reduction mod Q
module modq_mulred
  import modq_pkg::*;
(
  input  residue_t x,
  input  residue_t y,
  output residue_t r
);
  localparam logic [2*W:0] QX = (2*W+1)'(Q);
  localparam logic [2*W:0] MUX = (2*W+1)'(MU);
  product_t p;
  logic [2*W:0] hm, t, d0, d1;
  // Quotient estimate undershoots by at most two, so two trial subtractions finish the reduction
  always_comb begin
    p = product_t'(x) * product_t'(y);
    hm = (2*W+1)'(p >> W) * MUX;
    t = hm >> W;
    d0 = {1'b0, p} - t * QX;
    d1 = d0 >= QX ? d0 - QX : d0;
    r = residue_t'(d1 >= QX ? d1 - QX : d1);
  end
endmodule

// File: rtl/modinv_769.sv
// modinv_769: constant-time Fermat inverter a^(Q-2) mod Q; MODINV_SELFCHECK_EN adds a base*acc==1 check state
module modinv_769
  import modq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_inv,
  output logic         out_err
);
  localparam int IW = $clog2(W);
`ifdef MODINV_SELFCHECK_EN
  localparam modinv_state_t FIN = CHK;
`else
  localparam modinv_state_t FIN = DONE;
`endif
  modinv_state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  residue_t acc_q, acc_d, base_q, base_d, inv_q, inv_d, r, y;
  logic err_q, err_d, oerr_q, oerr_d, bad, fault;
  assign y = state_q == SQR ? acc_q : base_q;
  modq_mulred u_mulred (.x(acc_q), .y(y), .r(r));
`ifdef MODINV_SELFCHECK_EN
  assign fault = state_q == CHK && r != residue_t'(1) && !err_q;
`else
  assign fault = 1'b0;
`endif
  assign bad = in_a == '0 || in_a >= residue_t'(Q);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_inv = inv_q;
  assign out_err = oerr_q;
  // Square-and-multiply schedule over every exponent bit; outputs load only when entering DONE
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    acc_d = acc_q;
    base_d = base_q;
    err_d = err_q;
    inv_d = inv_q;
    oerr_d = oerr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        base_d = bad ? residue_t'(1) : in_a;
        err_d = bad;
        acc_d = residue_t'(1);
        i_d = IW'(W - 1);
        state_d = SQR;
      end
      SQR: begin
        acc_d = r;
        if (EXP[i_q]) state_d = MUL;
        else if (i_q == '0) state_d = FIN;
        else i_d = i_q - 1'b1;
      end
      MUL: begin
        acc_d = r;
        if (i_q == '0) state_d = FIN;
        else begin
          i_d = i_q - 1'b1;
          state_d = SQR;
        end
      end
      CHK: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      inv_d = (err_q || fault) ? '0 : acc_d;
      oerr_d = err_q || fault;
    end
  end
  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      acc_q <= '0;
      base_q <= '0;
      err_q <= 1'b0;
      inv_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      acc_q <= acc_d;
      base_q <= base_d;
      err_q <= err_d;
      inv_q <= inv_d;
      oerr_q <= oerr_d;
    end
  end
endmodule

// File: tb/tb_modinv_769.sv
// tb_modinv_769: randomized and directed checks of modinv_769 against a brute-force inverse model
module tb_modinv_769;
  localparam int QM = 769;
`ifdef MODINV_SELFCHECK_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [9:0] in_a = '0;
  logic [9:0] out_inv;
  int n_chk = 0, n_pass = 0, cyc = 0;
  modinv_769 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_err(out_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int ref_inv(input int a);
    if (a == 0 || a >= QM) return 0;
    for (int b = 1; b < QM; b++) if ((a * b) % QM == 1) return b;
    return 0;
  endfunction
  task automatic do_op(input int a, input int hold, output int inv, output int err, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_a = 10'(a);
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_a = 10'($urandom_range(0, 1023));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    inv = int'(out_inv);
    err = int'(out_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 10'd5;
      @(posedge clk);
      #1 check("hold_ready", int'(in_ready), 0);
      check("hold_valid", int'(out_valid), 1);
      check("hold_inv", int'(out_inv), inv);
      check("hold_err", int'(out_err), err);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("done_ready", int'(in_ready), 1);
    check("done_valid", int'(out_valid), 0);
  endtask
  task automatic run_check(input int a, input int hold);
    int inv, err, lat;
    do_op(a, hold, inv, err, lat);
    check($sformatf("lat_%0d", a), lat, LAT);
    check($sformatf("inv_%0d", a), inv, ref_inv(a));
    check($sformatf("err_%0d", a), err, (a == 0 || a >= QM) ? 1 : 0);
  endtask
  initial begin
    int inv, err, lat, t_prev, n;
    #2;
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_inv", int'(out_inv), 0);
    check("rst_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2, 0, inv, err, lat);
    check("a2_inv", inv, 385);
    check("a2_err", err, 0);
    check("a2_lat", lat, LAT);
    do_op(3, 0, inv, err, lat);
    check("a3_inv", inv, 513);
    run_check(1, 0);
    run_check(768, 0);
    run_check(0, 0);
    run_check(800, 0);
    run_check(11, 5);
    run_check(5, 0);
    for (int k = 0; k < 20; k++) run_check(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 10'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_inv", int'(out_inv), 0);
    check("mid_rst_err", int'(out_err), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(in_ready), 1);
    do_op(7, 0, inv, err, lat);
    check("a7_inv", inv, 110);
    check("a7_lat", lat, LAT);
    out_ready = 1'b1;
    in_valid = 1'b1;
    t_prev = 0;
    for (int a = 1; a < QM; a++) begin
      in_a = 10'(a);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      if (a > 1) check("sweep_gap", cyc - t_prev, LAT + 2);
      t_prev = cyc;
      #1 n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      check("sweep_prod", (a * int'(out_inv)) % QM, 1);
      check("sweep_err", int'(out_err), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
